// File: rtl/reset_pulse_gen.sv
// Merges a debounced pushbutton and a software strobe into single-cycle reset pulses with a holdoff between them.
// sw_req -> pulse in 1 cycle; btn_in -> pulse in DEBOUNCE_CYCLES+4; requests while busy are dropped (counted with RESET_PULSE_DROP_CNT_EN).
module reset_pulse_gen #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLDOFF_CYCLES  = 64,
  parameter int DROP_W          = 8
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              btn_in,
  input  logic              sw_req,
  output logic              reset_pulse,
`ifdef RESET_PULSE_DROP_CNT_EN
  output logic [DROP_W-1:0] drop_cnt,
`endif
  output logic              busy
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam int HO_W = $clog2(HOLDOFF_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HO_W-1:0] HO_MAX = HO_W'(HOLDOFF_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t          r_state;
  logic            r_btn_s1;
  logic            r_btn_s2;
  logic            r_btn_db;
  logic            r_btn_db_q;
  logic            r_btn_req;
  logic [DB_W-1:0] r_db_cnt;
  logic [HO_W-1:0] r_ho_cnt;
  logic            w_req;
  logic            w_busy;

  assign w_req       = r_btn_req | sw_req;
  assign w_busy      = (r_state == PULSE) || (r_state == HOLD);
  assign reset_pulse = (r_state == PULSE);
  assign busy        = w_busy;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_btn_s1   <= 1'b0;
      r_btn_s2   <= 1'b0;
      r_btn_db   <= 1'b0;
      r_btn_db_q <= 1'b0;
      r_btn_req  <= 1'b0;
      r_db_cnt   <= '0;
    end else begin
      r_btn_s1   <= btn_in;
      r_btn_s2   <= r_btn_s1;
      r_btn_db_q <= r_btn_db;
      r_btn_req  <= r_btn_db & ~r_btn_db_q;
      // The debounced level only moves after DEBOUNCE_CYCLES consecutive disagreeing samples.
      if (r_btn_s2 == r_btn_db) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_MAX) begin
        r_btn_db <= r_btn_s2;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state  <= IDLE;
      r_ho_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req) r_state <= PULSE;
        end
        PULSE: begin
          r_ho_cnt <= HO_MAX;
          r_state  <= HOLD;
        end
        HOLD: begin
          if (r_ho_cnt == '0) r_state <= IDLE;
          else                r_ho_cnt <= r_ho_cnt - 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef RESET_PULSE_DROP_CNT_EN
  logic [DROP_W-1:0] r_drop_cnt;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_drop_cnt <= '0;
    end else if (w_req && w_busy && (r_drop_cnt != {DROP_W{1'b1}})) begin
      r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  assign drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_reset_pulse_gen.sv
// Directed bench for reset_pulse_gen: expected pulse cycles are queued by the stimulus and checked by a monitor.
module tb_reset_pulse_gen;

  localparam int DEB = 16;
  localparam int HO  = 64;

  logic clk = 1'b0;
  logic clr = 1'b1;
  logic btn_in = 1'b0;
  logic sw_req = 1'b0;
  logic reset_pulse;
  logic busy;
`ifdef RESET_PULSE_DROP_CNT_EN
  logic [1:0] drop_cnt;
`endif

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int exp_q[$];
  int blen     = 0;
  bit abort    = 1'b0;

  reset_pulse_gen #(
    .DEBOUNCE_CYCLES(DEB),
    .HOLDOFF_CYCLES (HO),
    .DROP_W         (2)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .btn_in     (btn_in),
    .sw_req     (sw_req),
    .reset_pulse(reset_pulse),
`ifdef RESET_PULSE_DROP_CNT_EN
    .drop_cnt   (drop_cnt),
`endif
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_to(input int target);
    while (cyc < target) tick(1);
  endtask

  // Pulse scoreboard and busy-length monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset_pulse || (exp_q.size() > 0 && exp_q[0] <= cyc)) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_pulse at cycle %0d: got pulse expected none", cyc);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (!reset_pulse || e != cyc) begin
          n_err++;
          $display("FAIL pulse_time: got pulse=%0d at cycle %0d expected pulse at cycle %0d",
                   reset_pulse, cyc, e);
        end
      end
    end
    if (busy) begin
      blen++;
      if (clr) abort = 1'b1;
    end else if (blen != 0) begin
      if (!abort) check("busy_len", blen, HO + 1);
      blen  = 0;
      abort = 1'b0;
    end
  end

  initial begin
    int c;
    tick(3);
    clr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("idle_busy", busy, 0);
      check("idle_pulse", reset_pulse, 0);
      tick(1);
    end
`ifdef RESET_PULSE_DROP_CNT_EN
    check("idle_drop", drop_cnt, 0);
`endif

    // Single software strobe; busy window checked by the monitor and at its edges.
    c = cyc;
    sw_req = 1'b1;
    exp_q.push_back(c + 1);
    tick(1);
    sw_req = 1'b0;
    check("sw_busy_first", busy, 1);
    wait_to(c + HO + 1);
    check("sw_busy_last", busy, 1);
    tick(1);
    check("sw_busy_clear", busy, 0);

    // Short glitch is ignored, a long press gives one pulse, release gives none.
    btn_in = 1'b1;
    tick(DEB - 6);
    btn_in = 1'b0;
    tick(30);
    c = cyc;
    btn_in = 1'b1;
    exp_q.push_back(c + DEB + 4);
    tick(40);
    btn_in = 1'b0;
    tick(60);
    check("btn_idle_after", busy, 0);

    // Button and software request in the same cycle merge into one pulse.
    c = cyc;
    btn_in = 1'b1;
    exp_q.push_back(c + DEB + 4);
    wait_to(c + DEB + 3);
    sw_req = 1'b1;
    tick(1);
    sw_req = 1'b0;
    wait_to(c + DEB + 9);
    sw_req = 1'b1;
    tick(1);
    sw_req = 1'b0;
`ifdef RESET_PULSE_DROP_CNT_EN
    check("drop_one", drop_cnt, 1);
`endif
    btn_in = 1'b0;
    tick(90);

    // Drop counter clears on clr and saturates; final HOLD cycle still drops.
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    check("clr_busy", busy, 0);
`ifdef RESET_PULSE_DROP_CNT_EN
    check("clr_drop", drop_cnt, 0);
`endif
    c = cyc;
    sw_req = 1'b1;
    exp_q.push_back(c + 1);
    tick(1);
    sw_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wait_to(c + 5 + 5 * i);
      sw_req = 1'b1;
      tick(1);
      sw_req = 1'b0;
    end
`ifdef RESET_PULSE_DROP_CNT_EN
    check("drop_sat", drop_cnt, 3);
`endif
    wait_to(c + HO + 1);
    sw_req = 1'b1;
    tick(1);
    check("hold_exit_busy", busy, 0);
    exp_q.push_back(c + HO + 3);
    tick(1);
    sw_req = 1'b0;
    check("reaccept_busy", busy, 1);
    tick(70);

    // clr in the middle of HOLD aborts it; a request right after is accepted.
    c = cyc;
    sw_req = 1'b1;
    exp_q.push_back(c + 1);
    tick(1);
    sw_req = 1'b0;
    wait_to(c + 31);
    check("mid_hold_busy", busy, 1);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_pulse", reset_pulse, 0);
`ifdef RESET_PULSE_DROP_CNT_EN
    check("abort_drop", drop_cnt, 0);
`endif
    sw_req = 1'b1;
    exp_q.push_back(c + 33);
    tick(1);
    sw_req = 1'b0;
    check("post_clr_pulse", reset_pulse, 1);
    tick(80);

    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
